// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA key generator and its divider.
package rsa_pkg;

    localparam int KEY_W  = 16;
    localparam int T_W    = 18;
    localparam int LFSR_W = 8;

    // Feedback taps for x^8 + x^6 + x^5 + x^4 + 1 (bits 7, 5, 4, 3)
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ_P,
        S_WAIT_P,
        S_REQ_Q,
        S_WAIT_Q,
        S_CALC,
        S_DIV,
        S_UPD,
        S_CHECK,
        S_FIX,
        S_DONE,
        S_FAIL
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/rsa_keygen_div16_seq.sv
// Sequential restoring 16/16 divider: one quotient bit per cycle, done pulses
// after the last bit. A zero divisor naturally yields quo = FFFF, rem = dividend.
module div16_seq
    import rsa_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [KEY_W-1:0] dividend,
    input  logic [KEY_W-1:0] divisor,
    output logic [KEY_W-1:0] quo,
    output logic [KEY_W-1:0] rem,
    output logic             done
);

    localparam int CNT_W = $clog2(KEY_W + 1);

    logic [KEY_W-1:0] r_acc;
    logic [KEY_W-1:0] r_quo;
    logic [KEY_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    logic [KEY_W:0]   w_shift;
    logic [KEY_W-1:0] w_diff;
    logic             w_ge;

    // The remainder is always below the divisor, so the shifted partial
    // remainder needs one extra bit only for the compare.
    assign w_shift = {r_acc, r_quo[KEY_W-1]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_diff  = w_shift[KEY_W-1:0] - r_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (go) begin
                r_acc <= '0;
                r_quo <= dividend;
                r_div <= divisor;
                r_cnt <= CNT_W'(KEY_W);
            end else if (r_cnt != '0) begin
                r_acc  <= w_ge ? w_diff : w_shift[KEY_W-1:0];
                r_quo  <= {r_quo[KEY_W-2:0], w_ge};
                r_cnt  <= r_cnt - CNT_W'(1);
                r_done <= (r_cnt == CNT_W'(1));
            end
        end
    end

    assign quo  = r_quo;
    assign rem  = r_acc;
    assign done = r_done;

endmodule

// File: rtl/rsa_keygen.sv
// RSA key generator: fetches two primes, picks the smallest coprime odd e and
// derives d = e^-1 mod phi with an iterative extended Euclid loop.
module rsa_keygen
    import rsa_pkg::*;
#(
    parameter logic [KEY_W-1:0]  E_START   = 16'd3,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              prime_req,
    output logic [LFSR_W-1:0] prime_idx,
    input  logic [7:0]        prime_in,
    input  logic              prime_vld,
    output logic              busy,
    output logic              key_vld,
    output logic              err,
    output logic [KEY_W-1:0]  n,
    output logic [KEY_W-1:0]  e,
    output logic [KEY_W-1:0]  d
);

    state_t r_state;
    state_t w_state_next;

    logic [LFSR_W-1:0]     r_lfsr;
    logic [7:0]            r_p;
    logic [7:0]            r_q;
    logic [KEY_W-1:0]      r_phi;
    logic [KEY_W-1:0]      r_e_cur;
    logic [KEY_W-1:0]      r_old_r;
    logic [KEY_W-1:0]      r_r;
    logic signed [T_W-1:0] r_old_t;
    logic signed [T_W-1:0] r_t;
    logic                  r_div_pend;

    logic                  r_prime_req;
    logic [LFSR_W-1:0]     r_prime_idx;
    logic                  r_busy;
    logic                  r_key_vld;
    logic                  r_err;
    logic [KEY_W-1:0]      r_n;
    logic [KEY_W-1:0]      r_e;
    logic [KEY_W-1:0]      r_d;

    logic [KEY_W-1:0]      w_pm1;
    logic [KEY_W-1:0]      w_qm1;
    logic [KEY_W-1:0]      w_phi;
    logic [KEY_W-1:0]      w_n;
    logic [KEY_W:0]        w_e_inc;
    logic signed [T_W-1:0] w_qt;
    logic signed [T_W-1:0] w_t_new;
    logic [KEY_W-1:0]      w_d_fix;
    logic [LFSR_W-1:0]     w_lfsr_next;
    logic                  w_div_go;
    logic                  w_div_done;
    logic                  w_req_next;
    logic [KEY_W-1:0]      w_quo;
    logic [KEY_W-1:0]      w_rem;

    assign w_lfsr_next = lfsr_step(r_lfsr);
    assign w_pm1       = {8'd0, r_p} - KEY_W'(1);
    assign w_qm1       = {8'd0, r_q} - KEY_W'(1);
    assign w_phi       = w_pm1 * w_qm1;
    assign w_n         = {8'd0, r_p} * {8'd0, r_q};
    assign w_e_inc     = {1'b0, r_e_cur} + (KEY_W+1)'(2);
    // Coefficients stay within +/-phi, so an 18-bit product never wraps.
    assign w_qt        = $signed({2'b00, w_quo}) * r_t;
    assign w_t_new     = r_old_t - w_qt;
    assign w_d_fix     = r_old_t[KEY_W-1:0] + (r_old_t[T_W-1] ? r_phi : '0);
    assign w_req_next  = (w_state_next == S_REQ_P) || (w_state_next == S_REQ_Q);

    div16_seq u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (w_div_go),
        .dividend (r_old_r),
        .divisor  (r_r),
        .quo      (w_quo),
        .rem      (w_rem),
        .done     (w_div_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_div_go     = 1'b0;
        case (r_state)
            S_IDLE:   if (start) w_state_next = S_REQ_P;
            S_REQ_P:  w_state_next = S_WAIT_P;
            S_WAIT_P: if (prime_vld) w_state_next = S_REQ_Q;
            S_REQ_Q:  w_state_next = S_WAIT_Q;
            S_WAIT_Q: if (prime_vld) w_state_next = S_CALC;
            S_CALC:   w_state_next = ((r_p == r_q) || (E_START >= w_phi)) ? S_FAIL : S_DIV;
            S_DIV: begin
                w_div_go = !r_div_pend;
                if (w_div_done) w_state_next = S_UPD;
            end
            S_UPD:    w_state_next = (w_rem == '0) ? S_CHECK : S_DIV;
            S_CHECK: begin
                if (r_old_r == KEY_W'(1))        w_state_next = S_FIX;
                else if (w_e_inc >= {1'b0, r_phi}) w_state_next = S_FAIL;
                else                             w_state_next = S_DIV;
            end
            S_FIX:    w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            S_FAIL:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr      <= LFSR_SEED;
            r_p         <= '0;
            r_q         <= '0;
            r_phi       <= '0;
            r_e_cur     <= '0;
            r_old_r     <= '0;
            r_r         <= '0;
            r_old_t     <= '0;
            r_t         <= '0;
            r_div_pend  <= 1'b0;
            r_prime_req <= 1'b0;
            r_prime_idx <= '0;
            r_busy      <= 1'b0;
            r_key_vld   <= 1'b0;
            r_err       <= 1'b0;
            r_n         <= '0;
            r_e         <= '0;
            r_d         <= '0;
        end else begin
            r_lfsr      <= w_lfsr_next;
            r_prime_req <= w_req_next;
            if (w_req_next) r_prime_idx <= w_lfsr_next;

            if (w_div_go)        r_div_pend <= 1'b1;
            else if (w_div_done) r_div_pend <= 1'b0;

            case (r_state)
                S_IDLE: if (start) begin
                    r_busy    <= 1'b1;
                    r_key_vld <= 1'b0;
                    r_err     <= 1'b0;
                end
                S_WAIT_P: if (prime_vld) r_p <= prime_in;
                S_WAIT_Q: if (prime_vld) r_q <= prime_in;
                S_CALC: begin
                    r_phi   <= w_phi;
                    r_e_cur <= E_START;
                    r_old_r <= w_phi;
                    r_r     <= E_START;
                    r_old_t <= '0;
                    r_t     <= T_W'(1);
                end
                S_UPD: begin
                    r_old_r <= r_r;
                    r_r     <= w_rem;
                    r_old_t <= r_t;
                    r_t     <= w_t_new;
                end
                S_CHECK: if (r_old_r != KEY_W'(1)) begin
                    r_e_cur <= w_e_inc[KEY_W-1:0];
                    r_old_r <= r_phi;
                    r_r     <= w_e_inc[KEY_W-1:0];
                    r_old_t <= '0;
                    r_t     <= T_W'(1);
                end
                S_FIX: begin
                    r_n <= w_n;
                    r_e <= r_e_cur;
                    r_d <= w_d_fix;
                end
                default: ;
            endcase

            if (w_state_next == S_DONE) begin
                r_key_vld <= 1'b1;
                r_busy    <= 1'b0;
            end
            if (w_state_next == S_FAIL) begin
                r_err  <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    assign prime_req = r_prime_req;
    assign prime_idx = r_prime_idx;
    assign busy      = r_busy;
    assign key_vld   = r_key_vld;
    assign err       = r_err;
    assign n         = r_n;
    assign e         = r_e;
    assign d         = r_d;

endmodule

// File: tb/tb_rsa_keygen.sv
// Self-checking bench for rsa_keygen: directed key cases plus random prime
// pairs, each compared against an arithmetic RSA key model.
module tb_rsa_keygen;

    localparam int E_START = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        prime_vld = 1'b0;
    logic [7:0]  prime_in = '0;
    logic        prime_req;
    logic [7:0]  prime_idx;
    logic        busy;
    logic        key_vld;
    logic        err;
    logic [15:0] n;
    logic [15:0] e;
    logic [15:0] d;

    int checks = 0;
    int errors = 0;
    int req_total = 0;

    int exp_n = 0;
    int exp_e = 0;
    int exp_d = 0;

    logic [7:0] m_lfsr;

    int primes[54] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53,
                       59, 61, 67, 71, 73, 79, 83, 89, 97, 101, 103, 107, 109, 113,
                       127, 131, 137, 139, 149, 151, 157, 163, 167, 173, 179, 181,
                       191, 193, 197, 199, 211, 223, 227, 229, 233, 239, 241, 251};

    always #5 clk = ~clk;

    rsa_keygen #(
        .E_START   (16'd3),
        .LFSR_SEED (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .prime_req (prime_req),
        .prime_idx (prime_idx),
        .prime_in  (prime_in),
        .prime_vld (prime_vld),
        .busy      (busy),
        .key_vld   (key_vld),
        .err       (err),
        .n         (n),
        .e         (e),
        .d         (d)
    );

    // Index sequence: x^8+x^6+x^5+x^4+1 Fibonacci LFSR stepping every clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    always @(negedge clk) begin
        if (prime_req) req_total <= req_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic void ref_key(input int p, input int q, output bit fail,
                                    output int rn, output int re, output int rd);
        int phi;
        int ee;
        rn   = p * q;
        phi  = (p - 1) * (q - 1);
        re   = 0;
        rd   = 0;
        fail = 1'b0;
        if (p == q) begin
            fail = 1'b1;
            return;
        end
        ee = E_START;
        while (ee < phi && gcd(ee, phi) != 1) ee += 2;
        if (ee >= phi) begin
            fail = 1'b1;
            return;
        end
        re = ee;
        for (int k = 1; k < phi; k++) begin
            if ((longint'(ee) * k) % phi == 1) begin
                rd = k;
                break;
            end
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_key_vld"}, key_vld, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_n"}, n, 0);
        check({tag, "_e"}, e, 0);
        check({tag, "_d"}, d, 0);
        check({tag, "_prime_req"}, prime_req, 0);
        check({tag, "_prime_idx"}, prime_idx, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_prime(input int v);
        int w = 0;
        while (!prime_req && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("prime_req_seen", prime_req, 1);
        check("prime_idx", prime_idx, m_lfsr);
        repeat ($urandom_range(1, 4)) @(negedge clk);
        prime_vld = 1'b1;
        prime_in  = 8'(v);
        @(negedge clk);
        prime_vld = 1'b0;
        prime_in  = 8'($urandom);
    endtask

    task automatic run_key(input int p, input int q, input bit disturb);
        bit fail;
        int rn, re, rd;
        int r0;
        int waited = 0;
        ref_key(p, q, fail, rn, re, rd);
        r0 = req_total;
        pulse_start();
        check("busy_after_start", busy, 1);
        check("key_vld_cleared", key_vld, 0);
        check("err_cleared", err, 0);
        send_prime(p);
        send_prime(q);
        if (disturb) begin
            repeat (8) @(negedge clk);
            start     = 1'b1;
            prime_vld = 1'b1;
            prime_in  = 8'd7;
            @(negedge clk);
            start     = 1'b0;
            prime_vld = 1'b0;
            waited    = 9;
        end
        while (busy && waited < 8000) begin
            @(negedge clk);
            waited++;
        end
        check("busy_fall", busy, 0);
        if (p == q || (p - 1) * (q - 1) <= E_START)
            check("fast_fail_cycles", (waited <= 3), 1);
        if (!fail) begin
            exp_n = rn;
            exp_e = re;
            exp_d = rd;
        end
        check("key_vld", key_vld, !fail);
        check("err", err, fail);
        check("n", n, exp_n);
        check("e", e, exp_e);
        check("d", d, exp_d);
        check("prime_req_count", req_total - r0, 2);
        $display("key p=%0d q=%0d: key_vld=%0d err=%0d n=%0d e=%0d d=%0d (model fail=%0d n=%0d e=%0d d=%0d)",
                 p, q, key_vld, err, n, e, d, fail, exp_n, exp_e, exp_d);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_key(61, 53, 1'b0);
        run_key(3, 11, 1'b0);
        run_key(13, 13, 1'b0);
        run_key(2, 3, 1'b0);

        // Abort mid-Euclid (third divide for 61/53) and restart cleanly.
        pulse_start();
        send_prime(61);
        send_prime(53);
        repeat (48) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_div_reset");
        exp_n = 0;
        exp_e = 0;
        exp_d = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_key(3, 11, 1'b0);

        run_key(61, 53, 1'b1);

        for (int i = 0; i < 10; i++) begin
            run_key(primes[$urandom_range(0, 53)], primes[$urandom_range(0, 53)], 1'(i % 3 == 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
